pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline hazard and stall controller for the five-stage MIPS core. It sits beside the decode stage and produces per-stage stall, bubble and flush controls: load-use stalls (register forwarding cannot cover these), data-memory wait-state stalls with a timeout watchdog, and IF/ID flush on taken jumps and branches. It also keeps a saturating stall-cycle counter for performance debug.

## Interface
Parameters:
- WAIT_MAX, 16: max consecutive data-memory wait cycles before a timeout error; legal range 1..255.
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset, synchronous, active-high.
- id_reg1_read  in  1  decode stage reads rs.
- id_reg2_read  in  1  decode stage reads rt.
- id_reg1_addr  in  5  rs address in decode.
- id_reg2_addr  in  5  rt address in decode.
- id_jump  in  1  decode resolved a taken jump or branch.
- ex_aluop  in  4  aluop of the instruction in EX.
- ex_wreg  in  1  EX instruction writes the register file.
- ex_wd  in  5  EX destination register.
- dmem_req  in  1  MEM stage is performing LW/SW this cycle.
- dmem_ack  in  1  data memory completes the access this cycle.
- stall  out  5  hold enables: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB.
- bubble_idex  out  1  load a NOP into ID/EX at the next edge.
- bubble_memwb  out  1  load a NOP into MEM/WB at the next edge.
- flush_ifid  out  1  load a NOP into IF/ID at the next edge.
- jump_take  out  1  qualified jump: PC may load jump_addr.
- err  out  1  sticky data-memory timeout.
- stall_cnt  out  CNT_W  saturating count of cycles with stall[0]=1.

## Operation
- FSM states: RUN, MEM_WAIT, ERR. Reset state is RUN. Reset value of every output is 0, and wait_cnt is 0.
- mem_hold = dmem_req & !dmem_ack & (state != ERR).
- load_use = (ex_aluop == EXE_LW_OP) & ex_wreg & (ex_wd != 0) & ((id_reg1_read & id_reg1_addr == ex_wd) | (id_reg2_read & id_reg2_addr == ex_wd)).
- Priority is ERR, then mem_hold, then load_use, then jump.
  - ERR: stall = 5'b11111. Bubbles and flush are 0. Leaving ERR requires rst.
  - mem_hold: stall = 5'b01111, bubble_memwb = 1. Other controls are 0.
  - load_use, with no mem_hold: stall = 5'b00011, bubble_idex = 1, jump_take = 0, flush_ifid = 0. The jump decision is suppressed because decode operands are stale.
  - Otherwise: stall = 0, jump_take = id_jump, flush_ifid = id_jump.
- Stall, bubble, flush and jump_take outputs are combinational from the inputs and the state. err is the registered state bit.
- FSM transitions:
  - RUN → MEM_WAIT when mem_hold. wait_cnt is set to 1.
  - MEM_WAIT → RUN when dmem_ack or when !dmem_req. wait_cnt is cleared to 0.
  - MEM_WAIT stays in MEM_WAIT while mem_hold and wait_cnt < WAIT_MAX. wait_cnt increments each cycle.
  - MEM_WAIT → ERR when mem_hold and wait_cnt == WAIT_MAX.
- stall_cnt increments on each cycle where stall[0] = 1, including ERR cycles. It saturates at all-ones.
- ex_wd == 0 never causes a load-use stall, because $0 is never written.

## Timing
- Load-use stall lasts exactly 1 cycle. On the next cycle EX holds the bubble, so load_use drops and MEM forwarding supplies the load data.
- Memory wait: stall is asserted in the same cycle as dmem_req & !dmem_ack. It drops in the cycle where dmem_ack = 1, with zero added latency. A total of WAIT_MAX + 1 unacked cycles enters ERR, and err = 1 from the following cycle.
- Simultaneous load_use and mem_hold: the mem_hold pattern applies. load_use is re-evaluated after release and still yields its single cycle of stall.
- Simultaneous id_jump and load_use: jump_take = 0 in the stall cycle. It is asserted in the next cycle using forwarded operands.
- dmem_ack without dmem_req is ignored.
- rst asserted mid-wait: state becomes RUN, wait_cnt = 0, err = 0 and stall_cnt = 0 at that edge. All outputs are 0 while rst = 1.

## Structure
- The shared defines file holds EXE_LW_OP, the stall bit indices (STALL_PC .. STALL_MEMWB) and the state encodings (CTRL_RUN, CTRL_MEM_WAIT, CTRL_ERR).
- One sub-module, mem_wait_timer: contains wait_cnt, its compare against WAIT_MAX, and the timeout pulse. Parameters: WAIT_MAX. Ports: clk, rst, start, clear, expired.
- The FSM, hazard compare and stall_cnt stay in pipe_hazard_ctrl.

## Test plan
- Load-use: EX holds LW with ex_wd = 5, ID reads rs = 5. Required: stall = 00011 and bubble_idex = 1 for exactly one cycle, then stall = 0.
- Load to $0: EX holds LW with ex_wd = 0, ID rs = 0. Required: stall = 0 and no bubble.
- Memory wait: dmem_req = 1 with dmem_ack low for 3 cycles, then high. Required: stall = 01111 and bubble_memwb = 1 for 3 cycles, 0 in the ack cycle, and stall_cnt = 3.
- Timeout with WAIT_MAX = 4: dmem_req held, never acked. Required: err = 1 after the 5th unacked cycle, stall = 11111 thereafter. Then rst for 1 cycle: all outputs 0 and state RUN.
- Branch behind load: EX holds LW with ex_wd = 8, ID has a BEQ reading $8 and id_jump = 1. Required: cycle 0 gives jump_take = 0, flush_ifid = 0, bubble_idex = 1. Cycle 1 gives jump_take = 1 and flush_ifid = 1.
- Saturation with CNT_W = 4: 20 stall cycles. Required: stall_cnt = 15.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared opcodes, stall bit indices and FSM encodings for the hazard controller
package pipe_hazard_ctrl_pkg;
  localparam logic [3:0] EXE_LW_OP = 4'b1000;
  localparam int STALL_PC = 0;
  localparam int STALL_IFID = 1;
  localparam int STALL_IDEX = 2;
  localparam int STALL_EXMEM = 3;
  localparam int STALL_MEMWB = 4;
  localparam logic [4:0] STALL_ALL = 5'b11111;
  localparam logic [4:0] STALL_MEM = 5'b01111;
  localparam logic [4:0] STALL_LU = 5'b00011;
  typedef enum logic [1:0] {
    CTRL_RUN = 2'd0,
    CTRL_MEM_WAIT = 2'd1,
    CTRL_ERR = 2'd2
  } ctrl_state_e;
endpackage

// File: rtl/pipe_hazard_ctrl_mem_wait_timer.sv
// mem_wait_timer: counts consecutive unacked data-memory cycles and flags the one that exceeds WAIT_MAX
module mem_wait_timer #(
  parameter int WAIT_MAX = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic clear,
  output logic expired
);
  localparam int W = $clog2(WAIT_MAX + 1);
  localparam logic [W-1:0] MAX = W'(WAIT_MAX);
  logic [W-1:0] r_wait_cnt;
  always_ff @(posedge clk)
    r_wait_cnt <= (rst || clear) ? '0 :
                  (start && r_wait_cnt != MAX) ? r_wait_cnt + 1'b1 : r_wait_cnt;
  assign expired = start & (r_wait_cnt == MAX);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use, memory wait-state and jump-flush control for the five-stage pipeline
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_reg1_read,
  input  logic             id_reg2_read,
  input  logic [4:0]       id_reg1_addr,
  input  logic [4:0]       id_reg2_addr,
  input  logic             id_jump,
  input  logic [3:0]       ex_aluop,
  input  logic             ex_wreg,
  input  logic [4:0]       ex_wd,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  output logic [4:0]       stall,
  output logic             bubble_idex,
  output logic             bubble_memwb,
  output logic             flush_ifid,
  output logic             jump_take,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt
);
  ctrl_state_e r_state, w_next;
  logic w_err_st, w_mem_hold, w_load_use, w_expired, w_free;
  logic [CNT_W-1:0] r_stall_cnt;
  assign w_err_st = (r_state == CTRL_ERR);
  assign w_mem_hold = dmem_req & ~dmem_ack & ~w_err_st;
  assign w_load_use = (ex_aluop == EXE_LW_OP) & ex_wreg & (ex_wd != 5'd0) &
                      ((id_reg1_read & (id_reg1_addr == ex_wd)) |
                       (id_reg2_read & (id_reg2_addr == ex_wd)));
  assign w_free = ~rst & ~w_err_st & ~w_mem_hold;
  mem_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_timer (
    .clk(clk),
    .rst(rst),
    .start(w_mem_hold),
    .clear(~w_mem_hold),
    .expired(w_expired)
  );
  always_ff @(posedge clk)
    r_state <= rst ? CTRL_RUN : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      CTRL_RUN:      w_next = w_mem_hold ? CTRL_MEM_WAIT : CTRL_RUN;
      CTRL_MEM_WAIT: w_next = !w_mem_hold ? CTRL_RUN : w_expired ? CTRL_ERR : CTRL_MEM_WAIT;
      default:       w_next = CTRL_ERR;
    endcase
  end
  // rst forces every control low, even before the reset edge lands
  always_comb begin
    stall = rst ? 5'b0 : w_err_st ? STALL_ALL : w_mem_hold ? STALL_MEM :
            w_load_use ? STALL_LU : 5'b0;
    bubble_memwb = ~rst & w_mem_hold;
    bubble_idex = w_free & w_load_use;
    jump_take = w_free & ~w_load_use & id_jump;
    flush_ifid = w_free & ~w_load_use & id_jump;
    err = ~rst & w_err_st;
    stall_cnt = rst ? '0 : r_stall_cnt;
  end
  always_ff @(posedge clk)
    r_stall_cnt <= rst ? '0 :
                   (stall[STALL_PC] && r_stall_cnt != '1) ? r_stall_cnt + 1'b1 : r_stall_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and random checks of the hazard controller against a rule-level model
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;
  localparam int WM = 4;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;
  logic clk = 0, rst = 1;
  logic id_reg1_read = 0, id_reg2_read = 0, id_jump = 0, ex_wreg = 0, dmem_req = 0, dmem_ack = 0;
  logic [4:0] id_reg1_addr = 0, id_reg2_addr = 0, ex_wd = 0;
  logic [3:0] ex_aluop = 0;
  logic [4:0] stall;
  logic bubble_idex, bubble_memwb, flush_ifid, jump_take, err;
  logic [CW-1:0] stall_cnt;
  int total = 0, bad = 0;
  bit m_err = 0;
  int m_unacked = 0, m_cnt = 0;

  pipe_hazard_ctrl #(.WAIT_MAX(WM), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_reg1_read(id_reg1_read), .id_reg2_read(id_reg2_read),
    .id_reg1_addr(id_reg1_addr), .id_reg2_addr(id_reg2_addr),
    .id_jump(id_jump), .ex_aluop(ex_aluop), .ex_wreg(ex_wreg), .ex_wd(ex_wd),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .stall(stall), .bubble_idex(bubble_idex), .bubble_memwb(bubble_memwb),
    .flush_ifid(flush_ifid), .jump_take(jump_take), .err(err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic r1, input logic [4:0] a1, input logic r2, input logic [4:0] a2,
                        input logic jmp, input logic [3:0] op, input logic wr, input logic [4:0] wd,
                        input logic req, input logic ack);
    id_reg1_read = r1; id_reg1_addr = a1; id_reg2_read = r2; id_reg2_addr = a2;
    id_jump = jmp; ex_aluop = op; ex_wreg = wr; ex_wd = wd; dmem_req = req; dmem_ack = ack;
  endtask

  // Expected controls come from the priority rules; the model then advances one clock
  task automatic step(input string tag);
    logic [4:0] e_stall;
    logic e_bi, e_bm, e_fl, e_jt, hold, lu;
    hold = dmem_req && !dmem_ack && !m_err;
    lu = (ex_aluop == EXE_LW_OP) && ex_wreg && ex_wd != 0 &&
         ((id_reg1_read && id_reg1_addr == ex_wd) || (id_reg2_read && id_reg2_addr == ex_wd));
    e_stall = 0; e_bi = 0; e_bm = 0; e_fl = 0; e_jt = 0;
    if (rst) begin
    end else if (m_err) e_stall = 5'b11111;
    else if (hold) begin e_stall = 5'b01111; e_bm = 1; end
    else if (lu) begin e_stall = 5'b00011; e_bi = 1; end
    else begin e_jt = id_jump; e_fl = id_jump; end
    #1;
    chk({tag, ".stall"}, 32'(stall), 32'(e_stall));
    chk({tag, ".bubble_idex"}, 32'(bubble_idex), 32'(e_bi));
    chk({tag, ".bubble_memwb"}, 32'(bubble_memwb), 32'(e_bm));
    chk({tag, ".flush_ifid"}, 32'(flush_ifid), 32'(e_fl));
    chk({tag, ".jump_take"}, 32'(jump_take), 32'(e_jt));
    chk({tag, ".err"}, 32'(err), 32'(!rst && m_err));
    chk({tag, ".stall_cnt"}, 32'(stall_cnt), rst ? 32'd0 : 32'(m_cnt));
    @(posedge clk);
    if (rst) begin
      m_err = 0; m_unacked = 0; m_cnt = 0;
    end else begin
      if (e_stall[0] && m_cnt < CNT_MAX) m_cnt++;
      if (hold) begin
        m_unacked++;
        if (m_unacked > WM) m_err = 1;
      end else m_unacked = 0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("reset");
    rst = 0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    step("idle");
    // load-use: one stall cycle, then EX holds the bubble
    set_in(1, 5, 0, 0, 0, EXE_LW_OP, 1, 5, 0, 0);
    step("lu0");
    set_in(1, 5, 0, 0, 0, 4'd0, 0, 0, 0, 0);
    step("lu1");
    // load to $0 never stalls
    set_in(1, 0, 1, 0, 0, EXE_LW_OP, 1, 0, 0, 0);
    step("lu_zero");
    // memory wait of three cycles then ack
    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("memwait.stall", 32'(stall), 32'h0f);
      step("memwait");
    end
    dmem_ack = 1;
    #1 chk("memack.stall", 32'(stall), 32'h0);
    step("memack");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1 chk("memwait.cnt", 32'(stall_cnt), 32'd3);
    step("ack_no_req");
    // branch behind load: jump deferred by one cycle
    set_in(1, 8, 1, 9, 1, EXE_LW_OP, 1, 8, 0, 0);
    step("br0");
    set_in(1, 8, 1, 9, 1, 4'd0, 0, 0, 0, 0);
    #1 chk("br1.jump_take", 32'(jump_take), 32'd1);
    step("br1");
    // timeout: WM+1 unacked cycles enter ERR
    do_reset();
    set_in(1, 3, 0, 0, 1, EXE_LW_OP, 1, 3, 1, 0);
    for (int i = 0; i < WM + 1; i++) step("timeout_wait");
    #1 chk("timeout.err", 32'(err), 32'd1);
    for (int i = 0; i < 3; i++) step("err_hold");
    rst = 1;
    step("err_rst");
    rst = 0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("after_rst.err", 32'(err), 32'd0);
    step("after_rst");
    // saturation of the stall counter
    do_reset();
    set_in(0, 0, 1, 7, 0, EXE_LW_OP, 1, 7, 0, 0);
    for (int i = 0; i < 20; i++) step("sat");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("sat.cnt", 32'(stall_cnt), 32'd15);
    step("sat_end");
    // random traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      set_in(1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)),
             1'($urandom), $urandom_range(0, 1) ? EXE_LW_OP : 4'($urandom), 1'($urandom),
             5'($urandom_range(0, 3)), ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) == 0));
      step("rand");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
